uart_rx_unit: RTL

UART_RX_UNIT -- requirements
Module: uart_rx_unit

---
 rtl/uart_rx_unit.sv | 138 +++++++++++++
 1 files changed

// File: rtl/uart_rx_unit.sv
// uart_rx_unit: 8N1 UART receiver feeding a first-word-fall-through FIFO.
// Optional stop-bit framing check enabled by UART_RX_FRAMING_CHECK_EN.
module uart_rx_unit #(
  parameter int CLK_PER_BIT = 868,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rxd,
  input  logic       rd_en,
  output logic [7:0] rx_data,
  output logic       empty,
  output logic       overrun,
  output logic       frame_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [15:0] BIT_LAST  = 16'(CLK_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLK_PER_BIT / 2 - 1);
  localparam logic [AW:0] FULL_CNT  = (AW+1)'(FIFO_DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]    state;
  logic [15:0]   cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          rx_s1;
  logic          rx_s2;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   count;
  logic          stop_hit;
  logic          push_req;
  logic          bad_stop;
  logic          full;
  logic          do_pop;
  logic          do_push;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= rxd;
      rx_s2 <= rx_s1;
    end
  end

  assign stop_hit = (state == STOP) && (cnt == BIT_LAST);

`ifdef UART_RX_FRAMING_CHECK_EN
  assign push_req = stop_hit && rx_s2;
  assign bad_stop = stop_hit && !rx_s2;
`else
  assign push_req = stop_hit;
  assign bad_stop = 1'b0;
`endif

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = rd_en && !empty;
  // A pop in the same cycle frees the slot for a push into a full FIFO
  assign do_push = push_req && (!full || do_pop);
  assign rx_data = empty ? 8'h00 : mem[rp];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!rx_s2) begin
            state   <= START;
            cnt     <= '0;
            bit_cnt <= '0;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt   <= '0;
            state <= rx_s2 ? IDLE : DATA;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shreg   <= {rx_s2, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wp        <= '0;
      rp        <= '0;
      count     <= '0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      if (do_push && !do_pop) count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
      overrun   <= push_req && full && !do_pop;
      frame_err <= bad_stop;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn && do_push) mem[wp] <= shreg;
  end

endmodule
